// File: rtl/permutation_round_ctrl.sv
// ASCON permutation state register and round sequencer: loads an initial state,
// drives state plus round constant to the round datapath and captures its result.
module permutation_round_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [4:0][63:0] state_i,
  input  logic [4:0][63:0] round_result_i,
  output logic [4:0][63:0] round_state_o,
  output logic [7:0]       round_cst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [4:0][63:0] state_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS_A - 1);
  localparam logic [3:0] FIRST_A    = 4'd0;
  localparam logic [3:0] FIRST_B    = 4'(ROUNDS_A - ROUNDS_B);

  fsm_t             fsm;
  logic [3:0]       rnd;
  logic [4:0][63:0] state_q;
  logic [3:0]       first_rnd;

  // p_b runs the tail of the p_a schedule, so it simply starts later in it.
  function automatic logic [7:0] cst_of(input logic [3:0] r);
    return {4'd15 - r, r};
  endfunction

  assign first_rnd = mode_i ? FIRST_A : FIRST_B;

  // Constant, busy and done are registered alongside the state so the
  // datapath sees them aligned with the round index they belong to.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm         <= IDLE;
      rnd         <= 4'd0;
      state_q     <= '0;
      round_cst_o <= 8'h00;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state_q     <= state_i;
            rnd         <= first_rnd;
            round_cst_o <= cst_of(first_rnd);
            busy_o      <= 1'b1;
            fsm         <= RUN;
          end else begin
            round_cst_o <= 8'h00;
            busy_o      <= 1'b0;
            fsm         <= IDLE;
          end
        end
        RUN: begin
          state_q <= round_result_i;
          if (rnd == LAST_ROUND) begin
            round_cst_o <= 8'h00;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            fsm         <= DONE;
          end else begin
            rnd         <= rnd + 4'd1;
            round_cst_o <= cst_of(rnd + 4'd1);
          end
        end
        default: begin
          round_cst_o <= 8'h00;
          busy_o      <= 1'b0;
          done_o      <= 1'b0;
          fsm         <= IDLE;
        end
      endcase
    end
  end

  assign round_state_o = state_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Directed bench for permutation_round_ctrl: a stub round datapath feeds the
// controller and a scoreboard of constants and final states checks each run.
module tb_permutation_round_ctrl;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;

  typedef logic [4:0][63:0] state_t;

  logic       clock_i;
  logic       reset_i;
  logic       start_i;
  logic       mode_i;
  state_t     state_in;
  state_t     round_result;
  state_t     round_state;
  logic [7:0] round_cst;
  logic       busy;
  logic       done;
  state_t     state_out;

  bit         xor_stub;
  int         checks;
  int         errors;

  logic [7:0] cst_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                               8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  logic [7:0] cst_q[$];
  state_t     final_q[$];

  permutation_round_ctrl #(.ROUNDS_A(ROUNDS_A), .ROUNDS_B(ROUNDS_B)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .state_i        (state_in),
    .round_result_i (round_result),
    .round_state_o  (round_state),
    .round_cst_o    (round_cst),
    .busy_o         (busy),
    .done_o         (done),
    .state_o        (state_out)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Stand-in for constant addition -> S-box -> diffusion: only the constant XOR.
  always_comb begin
    round_result = round_state;
    if (xor_stub) round_result[2] = round_state[2] ^ {56'b0, round_cst};
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input state_t obs, input state_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic state_t rand_state();
    state_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // One permutation: push expectations, start (unless the start is already
  // pending), then pop and compare a constant every RUN cycle until done.
  task automatic apply_stimulus(input logic mode, input state_t st, input bit disturb,
                                input bit keep_start, input state_t next_st,
                                input bit pre_started);
    int         n;
    int         edges;
    state_t     exp_state;
    logic [7:0] exp_cst;
    n = mode ? ROUNDS_A : ROUNDS_B;
    exp_state = st;
    for (int i = ROUNDS_A - n; i < ROUNDS_A; i++) begin
      cst_q.push_back(cst_tab[i]);
      if (xor_stub) exp_state[2] = exp_state[2] ^ {56'b0, cst_tab[i]};
    end
    final_q.push_back(exp_state);
    if (!pre_started) begin
      start_i  = 1'b1;
      mode_i   = mode;
      state_in = st;
    end
    tick();
    edges = 1;
    if (keep_start) state_in = next_st;
    else start_i = 1'b0;
    while (!done && edges < 40) begin
      check_bit("busy_in_run", busy, 1'b1);
      exp_cst = (cst_q.size() > 0) ? cst_q.pop_front() : 8'hxx;
      check_byte("round_cst", round_cst, exp_cst);
      if (disturb) begin
        start_i  = 1'($urandom_range(0, 1));
        state_in = rand_state();
        mode_i   = ~mode_i;
      end
      tick();
      edges++;
    end
    if (!keep_start) start_i = 1'b0;
    check_bit("done_pulse", done, 1'b1);
    check_int("start_to_done_cycles", edges, n + 1);
    check_output("final_state", state_out, final_q.pop_front());
    check_byte("cst_at_done", round_cst, 8'h00);
    check_bit("busy_at_done", busy, 1'b0);
    check_int("constants_left", cst_q.size(), 0);
    cst_q.delete();
    if (!keep_start) begin
      tick();
      check_bit("done_one_cycle", done, 1'b0);
      check_output("state_held", state_out, exp_state);
    end
  endtask

  initial begin
    state_t a_state;
    state_t b_state;
    state_t ff_state;
    bit     seen_done;
    checks   = 0;
    errors   = 0;
    xor_stub = 1'b1;
    reset_i  = 1'b1;
    start_i  = 1'b0;
    mode_i   = 1'b0;
    state_in = rand_state();
    repeat (2) tick();
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_byte("reset_cst", round_cst, 8'h00);
    check_output("reset_state", state_out, '0);
    reset_i = 1'b0;
    tick();

    $display("[TB] p_a from zero state");
    apply_stimulus(1'b1, '0, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] p_b with word 2 = 0xFF");
    ff_state    = '0;
    ff_state[2] = 64'hFF;
    apply_stimulus(1'b0, ff_state, 1'b0, 1'b0, '0, 1'b0);
    check_output("pb_word2_ee", state_out, {64'h0, 64'h0, 64'hEE, 64'h0, 64'h0});

    $display("[TB] p_b with start/mode/state disturbed mid-run");
    apply_stimulus(1'b0, ff_state, 1'b1, 1'b0, '0, 1'b0);

    $display("[TB] back-to-back p_a with start held across done");
    a_state = rand_state();
    b_state = rand_state();
    apply_stimulus(1'b1, a_state, 1'b0, 1'b1, b_state, 1'b0);
    apply_stimulus(1'b1, b_state, 1'b0, 1'b0, '0, 1'b1);

    $display("[TB] reset during round 5 of p_a");
    start_i  = 1'b1;
    mode_i   = 1'b1;
    state_in = rand_state();
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_byte("pre_reset_cst", round_cst, cst_tab[k]);
      tick();
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check_byte("abort_cst", round_cst, 8'h00);
    check_output("abort_state", state_out, '0);
    seen_done = 1'b0;
    repeat (15) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check_bit("no_done_after_abort", seen_done, 1'b0);
    apply_stimulus(1'b1, ff_state, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] identity datapath with random state");
    xor_stub = 1'b0;
    a_state  = rand_state();
    apply_stimulus(1'b0, a_state, 1'b0, 1'b0, '0, 1'b0);
    a_state = rand_state();
    apply_stimulus(1'b1, a_state, 1'b0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/permutation_round_ctrl.md
Name: permutation_round_ctrl

Overview:
- Sequential state holder and round sequencer for the ASCON permutation. It sits directly downstream of the linear diffusion layer.
- It holds the 320-bit state register and feeds the current state plus a round constant into the combinational round datapath (constant addition -> substitution -> diffusion).
- It captures the diffusion output back into the register once per cycle, and iterates 12 rounds (p_a) or 6 rounds (p_b) under a start/done handshake.

Parameters:
- ROUNDS_A, 12, number of rounds when mode_i = 1.
- ROUNDS_B, 6, number of rounds when mode_i = 0. Must be <= ROUNDS_A.

Ports:
- clock_i  in  1  system clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a permutation; sampled only when not busy.
- mode_i  in  1  1 = p_a (ROUNDS_A rounds), 0 = p_b (ROUNDS_B rounds); sampled with start_i.
- state_i  in  320 (type_state, 5x64)  initial state, loaded on accepted start.
- round_result_i  in  320 (type_state)  output of the diffusion layer for the current round.
- round_state_o  out  320 (type_state)  current state register, driven to the round datapath.
- round_cst_o  out  8  round constant for the current round.
- busy_o  out  1  high while rounds are in progress.
- done_o  out  1  one-cycle pulse when the final round has been captured.
- state_o  out  320 (type_state)  permutation result; equals the state register.

Behaviour:
- Reset (sync, reset_i=1 at edge): state register = 0, round index = 0, FSM = IDLE, busy_o = 0, done_o = 0, round_cst_o = 0x00. Reset overrides everything, including mid-run; the run is aborted and no done_o pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start_i=1: state register <= state_i.
  - Round index i <= ROUNDS_A - N, where N = ROUNDS_A if mode_i else ROUNDS_B.
  - Go to RUN.
  - Otherwise hold.
- RUN:
  - busy_o = 1.
  - Each edge: state register <= round_result_i and i <= i + 1.
  - On the edge where i = ROUNDS_A - 1 is consumed, go to DONE.
- DONE:
  - done_o = 1 and busy_o = 0 for exactly one cycle; state register holds.
  - DONE behaves as IDLE for start_i. A start_i in this cycle is accepted (back-to-back permutations); otherwise go to IDLE.
- round_cst_o: in RUN = {4'(15 - i), 4'(i)}. For p_a this gives 0xF0, 0xE1, 0xD2, …, 0x4B; p_b starts at i = 6 (0x96). It is 0x00 outside RUN.
- Arithmetic/width: i is 4 bits; it never exceeds ROUNDS_A - 1 in RUN and never wraps.
- Timing: start accepted at edge E0. Rounds are captured at edges E1..EN. done_o is high in the cycle following EN. Start-to-done = N+1 cycles.
- round_state_o and state_o are both the register value. state_o is valid while done_o = 1 and is held in IDLE until the next accepted start.
- start_i while busy_o = 1 is ignored, and mode_i/state_i changes are ignored. mode_i is latched only at acceptance.
- round_result_i is ignored outside RUN.

Test Plan:
- Bench stub round_result_i = round_state_o with word 2 XOR {56'b0, round_cst_o}. Stimulus: state_i = 0, mode_i = 1, start -> round_cst_o sequence F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B on consecutive cycles. done_o is high exactly 13 cycles after the start edge, and state_o word 2 = 0x00.
- Same stub, mode_i = 0, state_i word 2 = 0xFF -> constants 96, 87, 78, 69, 5A, 4B. done_o comes 7 cycles after start, and state_o word 2 = 0xFF ^ 0x11 = 0xEE.
- start_i pulsed repeatedly mid-run, with state_i changed -> no restart; count, constants and result identical to the undisturbed run.
- start_i held high across done_o -> second permutation begins the cycle after done_o. The second run uses state_o of the first run as its input only if the bench drives state_i from state_o; otherwise it loads the new state_i.
- reset_i asserted in round 5 of p_a -> next cycle busy_o = 0, done_o = 0, state_o = 0, round_cst_o = 0x00. No done_o pulse follows, and a subsequent start runs the full 12 rounds.
- Identity stub (round_result_i = round_state_o) with a random state_i -> state_o == state_i at done_o.
